// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter/sequencer sharing one SPI controller among N_REQ requesters.
// Optional watchdog abort in RUN enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arb #(
  parameter int N_REQ          = 4,
  parameter int IDW            = 2,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   cfg_cpol,
  input  logic [N_REQ-1:0]   cfg_cpha,
  input  logic [4*N_REQ-1:0] cfg_len,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   ss_n_out,
  output logic [IDW-1:0]     active_id,
  output logic               busy,
  output logic               err,
  output logic               ctrl_rst,
  output logic               ctrl_en,
  output logic               ctrl_cpol,
  output logic               ctrl_cpha,
  output logic [3:0]         ctrl_xfer_len,
  input  logic               ctrl_ss,
  input  logic               ctrl_busy,
  input  logic               ctrl_done
);
  typedef enum logic [1:0] {IDLE, CFG, RUN, GUARD} state_t;
  state_t         state;
  logic [IDW-1:0] ptr, win;
  logic           any, done_seen, fin, to_hit, to_rst;
  logic [3:0]     gcnt;
  int             idx;
  // Scan from farthest to nearest so the first set bit after ptr wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        win = IDW'(idx);
        any = 1'b1;
      end
    end
  end
  assign fin      = state == RUN && done_seen && !ctrl_busy;
  assign ctrl_en  = state == RUN && !(done_seen && !ctrl_busy);
  assign ctrl_rst = !rst_n || state == CFG || to_rst;
  assign busy     = state != IDLE;
  assign ss_n_out = state == RUN ? (~gnt | {N_REQ{ctrl_ss}}) : '1;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign to_hit = state == RUN && !fin && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt   <= '0;
      err    <= 1'b0;
      to_rst <= 1'b0;
    end else begin
      tcnt   <= state == RUN ? tcnt + 1'b1 : '0;
      err    <= err | to_hit;
      to_rst <= to_hit;
    end
  end
`else
  assign to_hit = 1'b0;
  assign to_rst = 1'b0;
  assign err    = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= IDW'(N_REQ - 1);
      gnt           <= '0;
      ack           <= '0;
      active_id     <= '0;
      ctrl_cpol     <= 1'b0;
      ctrl_cpha     <= 1'b0;
      ctrl_xfer_len <= '0;
      done_seen     <= 1'b0;
      gcnt          <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (any) begin
          state         <= CFG;
          gnt           <= N_REQ'(1) << win;
          active_id     <= win;
          ctrl_cpol     <= cfg_cpol[win];
          ctrl_cpha     <= cfg_cpha[win];
          ctrl_xfer_len <= cfg_len[{win, 2'b00} +: 4];
        end
        CFG: begin
          ptr       <= active_id;
          done_seen <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          if (ctrl_done) done_seen <= 1'b1;
          if (fin || to_hit) begin
            ack       <= gnt;
            gnt       <= '0;
            done_seen <= 1'b0;
            gcnt      <= 4'(GUARD_CYCLES - 1);
            state     <= GUARD;
          end
        end
        default: begin
          gcnt <= gcnt - 1'b1;
          if (gcnt == 4'd0) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: randomized transaction-level check of spi_arb against a round-robin reference model.
module tb_spi_arb;
  localparam int N = 4;
  localparam int G = 2;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, cfg_cpol = '0, cfg_cpha = '0;
  logic [4*N-1:0] cfg_len = '0;
  logic [N-1:0] gnt, ack, ss_n_out;
  logic [1:0]   active_id;
  logic         busy, err, ctrl_rst, ctrl_en, ctrl_cpol, ctrl_cpha;
  logic [3:0]   ctrl_xfer_len;
  logic         ctrl_ss = 1'b1, ctrl_busy = 1'b0, ctrl_done = 1'b0;
  int           total = 0, bad = 0, ptr_m = N - 1;

  spi_arb #(.N_REQ(N), .IDW(2), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_len(cfg_len), .gnt(gnt), .ack(ack), .ss_n_out(ss_n_out), .active_id(active_id),
    .busy(busy), .err(err), .ctrl_rst(ctrl_rst), .ctrl_en(ctrl_en), .ctrl_cpol(ctrl_cpol),
    .ctrl_cpha(ctrl_cpha), .ctrl_xfer_len(ctrl_xfer_len), .ctrl_ss(ctrl_ss),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int next_win(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, ctrl_en, 0);
    chk({tag, "_rst"}, ctrl_rst, 1);
    chk({tag, "_ss"}, ss_n_out, 4'hf);
    chk({tag, "_id"}, active_id, 0);
    chk({tag, "_cfg"}, {ctrl_cpol, ctrl_cpha, ctrl_xfer_len}, 0);
  endtask

  // One full transaction: grant, config, run for blen busy cycles, done, ack.
  task automatic run_txn(input int exp_gap, input bit drop_early, input bit clear_after, input int blen);
    int w, gap;
    logic [N-1:0] one;
    logic [5:0] exp_cfg;
    logic [N-1:0] exp_ss;
    w = next_win(req, ptr_m);
    one = N'(1) << w;
    exp_cfg = {cfg_cpol[w], cfg_cpha[w], cfg_len[4*w +: 4]};
    gap = 0;
    forever begin
      @(negedge clk);
      if (gnt != 0 || gap >= 40) break;
      gap++;
      chk("gap_ss", ss_n_out, 4'hf);
    end
    if (exp_gap >= 0) chk("gap_len", gap, exp_gap);
    chk("cfg_gnt", gnt, one);
    chk("cfg_id", active_id, w);
    chk("cfg_rst", ctrl_rst, 1);
    chk("cfg_en", ctrl_en, 0);
    chk("cfg_ss", ss_n_out, 4'hf);
    chk("cfg_latch", {ctrl_cpol, ctrl_cpha, ctrl_xfer_len}, exp_cfg);
    ptr_m = w;
    cfg_cpol = N'($urandom);
    cfg_cpha = N'($urandom);
    cfg_len = (4*N)'($urandom);
    ctrl_busy = 1'b1;
    ctrl_ss = 1'b0;
    for (int i = 0; i < blen; i++) begin
      @(negedge clk);
      if (drop_early && i == 0) req[w] = 1'b0;
      ctrl_ss = 1'($urandom);
      #1;
      exp_ss = ~one | {N{ctrl_ss}};
      chk("run_en", ctrl_en, 1);
      chk("run_rst", ctrl_rst, 0);
      chk("run_ss", ss_n_out, exp_ss);
      chk("run_ack", ack, 0);
      chk("run_latch", {ctrl_cpol, ctrl_cpha, ctrl_xfer_len}, exp_cfg);
    end
    @(negedge clk);
    ctrl_busy = 1'b0;
    ctrl_done = 1'b1;
    ctrl_ss = 1'b1;
    #1 chk("done_en", ctrl_en, 1);
    @(negedge clk);
    ctrl_done = 1'b0;
    #1;
    chk("fin_en", ctrl_en, 0);
    chk("fin_ack", ack, 0);
    chk("fin_gnt", gnt, one);
    @(negedge clk);
    chk("ack", ack, one);
    chk("ack_gnt", gnt, 0);
    chk("ack_busy", busy, 1);
    chk("ack_ss", ss_n_out, 4'hf);
    chk("ack_err", err, 0);
    if (clear_after) req[w] = 1'b0;
  endtask

  initial begin
    #7 check_idle_outputs("rst");
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rel_rst", ctrl_rst, 0);
    // single request with fixed config
    @(negedge clk);
    cfg_cpol = 4'b0010;
    cfg_cpha = 4'b0000;
    cfg_len = 16'h0080;
    req = 4'b0010;
    run_txn(0, 1'b0, 1'b1, 8);
    // contention: all requesters held high
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cfg_len = 16'($urandom);
      run_txn(G, 1'b0, 1'b0, 1 + i);
    end
    // fairness: serve 2, then 0101 must pick 0 before 2
    req = 4'b0100;
    run_txn(G, 1'b0, 1'b1, 3);
    req = 4'b0101;
    chk("fair_model", next_win(req, ptr_m), 0);
    run_txn(G, 1'b0, 1'b1, 2);
    run_txn(G, 1'b0, 1'b1, 2);
    // early drop of req[3]
    req = 4'b1000;
    run_txn(G, 1'b1, 1'b0, 4);
    repeat (6) @(negedge clk);
    chk("drop_nogrant", gnt, 0);
    chk("drop_idle", busy, 0);
    // random traffic
    for (int i = 0; i < 25; i++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      cfg_cpol = N'($urandom);
      cfg_cpha = N'($urandom);
      cfg_len = (4*N)'($urandom);
      run_txn(i == 0 ? -1 : G, 1'b0, 1'b0, $urandom_range(1, 6));
    end
    // async reset in the middle of RUN
    repeat (5) @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    ctrl_busy = 1'b1;
    ctrl_ss = 1'b0;
    @(negedge clk);
    chk("pre_rst_en", ctrl_en, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("arst");
    ctrl_busy = 1'b0;
    ctrl_ss = 1'b1;
    req = '0;
    ptr_m = N - 1;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_ack", ack, 0);
    end
    req = 4'b1111;
    run_txn(-1, 1'b0, 1'b0, 2);
    run_txn(G, 1'b0, 1'b0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
